// File: rtl/fused_pkg.sv
// Shared types and constants for the fused-layer OFM writeback path.
package fused_pkg;

    // Writeback sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LANE_W = 32;   // one OFM BRAM word
    localparam int LANES  = 4;    // words per Global BRAM line
    localparam int ADDR_W = 32;   // address / size width

endpackage

// File: rtl/ofm_line_packer.sv
// Collects OFM words into a Global BRAM line. Word k lands in lane k%LANES;
// a line is emitted when the top lane fills or the last word arrives.
// Unused lanes of a short final line read as zero.
module ofm_line_packer
    import fused_pkg::*;
#(
    parameter int NUM_LANES = LANES,
    parameter int VEC_W     = LANE_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [VEC_W-1:0]             word,
    input  logic                         valid,
    input  logic                         last,
    output logic [NUM_LANES*VEC_W-1:0]   line,
    output logic                         line_valid
);

    localparam int LANE_CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    // acc only ever holds lanes written in the current line; everything above
    // the lane pointer is zero, which gives the zero fill for free.
    logic [NUM_LANES-1:0][VEC_W-1:0] acc;
    logic [NUM_LANES-1:0][VEC_W-1:0] next_line;
    logic [LANE_CW-1:0]              lane;
    logic                            lane_top;

    assign lane_top = (lane == LANE_CW'(NUM_LANES - 1));

    // Current accumulator with the incoming word dropped into its lane
    always_comb begin
        next_line       = acc;
        next_line[lane] = word;
    end

    // Lane pointer, accumulator and emitted line register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            lane       <= '0;
            line       <= '0;
            line_valid <= 1'b0;
        end else begin
            line_valid <= 1'b0;
            if (valid) begin
                if (last || lane_top) begin
                    line       <= next_line;
                    line_valid <= 1'b1;
                    acc        <= '0;
                    lane       <= '0;
                end else begin
                    acc  <= next_line;
                    lane <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fused_ofm_writeback.sv
// Drains the local OFM BRAM word by word and writes packed 128-bit lines
// back to the Global BRAM starting at a latched line address.
module fused_ofm_writeback
    import fused_pkg::*;
#(
    parameter int DATA_WIDTH_LOCAL  = LANE_W,
    parameter int DATA_WIDTH_GLOBAL = LANE_W * LANES,
    parameter int ADDR_WIDTH        = ADDR_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr_OFM,
    input  logic [ADDR_WIDTH-1:0]        size_OFM,
    output logic [ADDR_WIDTH-1:0]        rd_addr_ofm,
    output logic                         rd_en_ofm,
    input  logic [DATA_WIDTH_LOCAL-1:0]  data_ofm,
    output logic [ADDR_WIDTH-1:0]        wr_addr_global,
    output logic                         we_global,
    output logic [DATA_WIDTH_GLOBAL-1:0] data_out_global,
    output logic                         busy,
    output logic                         done
);

    localparam int NUM_LANES = DATA_WIDTH_GLOBAL / DATA_WIDTH_LOCAL;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   size_q;
    logic [ADDR_WIDTH-1:0]   line_idx;
    logic                    rd_last;
    logic                    rd_vld;      // read data present on data_ofm this cycle
    logic [1:0]              last_pipe;   // [0]: last word on data_ofm, [1]: last line on write port

    assign rd_last = rd_en_ofm && (rd_addr_ofm == size_q - ADDR_WIDTH'(1));

    // Line address wraps modulo 2^ADDR_WIDTH by construction of the adder
    assign wr_addr_global = base_q + line_idx;

    // Sequencer: latch the job, stream reads, wait for the last line, pulse done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            base_q      <= '0;
            size_q      <= '0;
            rd_addr_ofm <= '0;
            rd_en_ofm   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr_OFM;
                        size_q <= size_OFM;
                        if (size_OFM == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= READ;
                            rd_en_ofm   <= 1'b1;
                            rd_addr_ofm <= '0;
                            busy        <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_last) begin
                        rd_en_ofm <= 1'b0;
                        state     <= FLUSH;
                    end else begin
                        rd_addr_ofm <= rd_addr_ofm + ADDR_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    // last_pipe[1] coincides with the final we_global pulse
                    if (last_pipe[1]) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track BRAM read latency and the last-word marker alongside the data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld    <= 1'b0;
            last_pipe <= '0;
        end else begin
            rd_vld    <= rd_en_ofm;
            last_pipe <= {last_pipe[0], rd_last};
        end
    end

    // Output line index: cleared on an accepted start, advanced per write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_idx <= '0;
        end else if (state == IDLE && start) begin
            line_idx <= '0;
        end else if (we_global) begin
            line_idx <= line_idx + ADDR_WIDTH'(1);
        end
    end

    ofm_line_packer #(
        .NUM_LANES (NUM_LANES),
        .VEC_W     (DATA_WIDTH_LOCAL)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .word       (data_ofm),
        .valid      (rd_vld),
        .last       (last_pipe[0]),
        .line       (data_out_global),
        .line_valid (we_global)
    );

endmodule

// File: tb/tb_fused_ofm_writeback.sv
// Randomized self-checking bench for fused_ofm_writeback with a BRAM model
// and a line-level reference model of expected writes and timing.
module tb_fused_ofm_writeback;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [31:0]  base_addr_OFM;
    logic [31:0]  size_OFM;
    logic [31:0]  rd_addr_ofm;
    logic         rd_en_ofm;
    logic [31:0]  data_ofm;
    logic [31:0]  wr_addr_global;
    logic         we_global;
    logic [127:0] data_out_global;
    logic         busy;
    logic         done;

    logic [31:0]  mem [0:15];
    logic [127:0] hold_line;
    int           checks = 0;
    int           fails  = 0;

    fused_ofm_writeback dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr_OFM   (base_addr_OFM),
        .size_OFM        (size_OFM),
        .rd_addr_ofm     (rd_addr_ofm),
        .rd_en_ofm       (rd_en_ofm),
        .data_ofm        (data_ofm),
        .wr_addr_global  (wr_addr_global),
        .we_global       (we_global),
        .data_out_global (data_out_global),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read OFM BRAM: data valid the cycle after rd_en_ofm
    always @(posedge clk) begin
        if (rd_en_ofm === 1'b1) data_ofm <= mem[rd_addr_ofm[3:0]];
    end

    // One run: start at cycle 0, check every cycle 1..n+6 against the model
    task automatic run_case(input int n, input logic [31:0] base, input bit repulse, input string tag);
        logic [127:0] exp_data [$];
        logic [31:0]  exp_addr [$];
        int           exp_cyc  [$];
        logic [127:0] d;
        int nlines, done_cyc, wi, writes, dones, k, lastk;
        bit exp_we, exp_busy;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        nlines = (n + 3) / 4;
        for (int j = 0; j < nlines; j++) begin
            d = '0;
            for (int l = 0; l < 4; l++) begin
                k = 4 * j + l;
                if (k < n) d[32*l +: 32] = mem[k];
            end
            lastk = (4 * j + 3 < n) ? 4 * j + 3 : n - 1;
            exp_data.push_back(d);
            exp_addr.push_back(base + 32'(j));
            exp_cyc.push_back(lastk + 3);   // word arrives k+2, written the cycle after
        end
        done_cyc = (n == 0) ? 1 : n + 3;
        wi = 0; writes = 0; dones = 0;

        @(negedge clk);
        start = 1'b1; base_addr_OFM = base; size_OFM = 32'(n);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= n + 6; c++) begin
            checks++;
            if (rd_en_ofm !== (c <= n)) begin
                fails++; $display("FAIL %s rd_en c=%0d: got %b want %b", tag, c, rd_en_ofm, (c <= n));
            end
            if (c <= n) begin
                checks++;
                if (rd_addr_ofm !== 32'(c - 1)) begin
                    fails++; $display("FAIL %s rd_addr c=%0d: got %h want %h", tag, c, rd_addr_ofm, c - 1);
                end
            end
            exp_we = (wi < nlines) && (exp_cyc[wi] == c);
            checks++;
            if (we_global !== exp_we) begin
                fails++; $display("FAIL %s we c=%0d: got %b want %b", tag, c, we_global, exp_we);
            end
            if (exp_we) begin
                checks += 2;
                if (wr_addr_global !== exp_addr[wi]) begin
                    fails++; $display("FAIL %s wr_addr c=%0d: got %h want %h", tag, c, wr_addr_global, exp_addr[wi]);
                end
                if (data_out_global !== exp_data[wi]) begin
                    fails++; $display("FAIL %s line c=%0d: got %h want %h", tag, c, data_out_global, exp_data[wi]);
                end
                hold_line = exp_data[wi];
                wi++;
            end else begin
                checks++;
                if (data_out_global !== hold_line) begin
                    fails++; $display("FAIL %s hold c=%0d: got %h want %h", tag, c, data_out_global, hold_line);
                end
            end
            exp_busy = (n > 0) && (c <= n + 2);
            checks += 2;
            if (done !== (c == done_cyc)) begin
                fails++; $display("FAIL %s done c=%0d: got %b want %b", tag, c, done, (c == done_cyc));
            end
            if (busy !== exp_busy) begin
                fails++; $display("FAIL %s busy c=%0d: got %b want %b", tag, c, busy, exp_busy);
            end
            if (we_global === 1'b1) writes++;
            if (done === 1'b1) dones++;
            if (repulse && c == 3) begin
                start = 1'b1; base_addr_OFM = 32'h55; size_OFM = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks += 2;
        if (writes != nlines) begin
            fails++; $display("FAIL %s write_count: got %0d want %0d", tag, writes, nlines);
        end
        if (dones != 1) begin
            fails++; $display("FAIL %s done_count: got %0d want 1", tag, dones);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; base_addr_OFM = '0; size_OFM = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_en_ofm, we_global, busy, done} !== 4'b0 || rd_addr_ofm !== '0 ||
            wr_addr_global !== '0 || data_out_global !== '0) begin
            fails++; $display("FAIL reset_outputs: got en=%b we=%b busy=%b done=%b ra=%h wa=%h d=%h want all 0",
                              rd_en_ofm, we_global, busy, done, rd_addr_ofm, wr_addr_global, data_out_global);
        end
        hold_line = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single_line();   run_case(4, 32'h100, 1'b0, "n4");      endtask
    task automatic test_partial_line();  run_case(6, 32'h20, 1'b0, "n6");       endtask
    task automatic test_empty();         run_case(0, 32'h40, 1'b0, "n0");       endtask
    task automatic test_addr_wrap();     run_case(8, 32'hFFFF_FFFF, 1'b0, "wrap"); endtask
    task automatic test_start_ignored(); run_case(8, 32'h700, 1'b1, "repulse"); endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++)
            run_case(int'($urandom_range(1, 13)), $urandom, 1'b0, "rand");
    endtask

    task automatic test_abort();
        int wes;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        @(negedge clk);
        start = 1'b1; base_addr_OFM = 32'h300; size_OFM = 32'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);       // now mid-cycle 4
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_en_ofm, we_global, busy, done} !== 4'b0 || rd_addr_ofm !== '0 ||
            wr_addr_global !== '0 || data_out_global !== '0) begin
            fails++; $display("FAIL abort_outputs: got en=%b we=%b busy=%b done=%b ra=%h wa=%h d=%h want all 0",
                              rd_en_ofm, we_global, busy, done, rd_addr_ofm, wr_addr_global, data_out_global);
        end
        hold_line = '0;
        wes = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (we_global !== 1'b0) wes++;
        end
        checks++;
        if (wes != 0) begin
            fails++; $display("FAIL abort_no_write: got %0d writes want 0", wes);
        end
        reset_n = 1'b1;
        run_case(4, 32'h100, 1'b0, "restart");
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_partial_line();
        test_empty();
        test_addr_wrap();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
